kbd_report_fifo_wb: RTL and testbench

- Wishbone slave peripheral that buffers 32-bit keyboard reports strobed in from the SPI link block.
- The CPU drains reports through a small register map.
- Sits on one slot of the CPU's Wishbone peripheral bus, clocked by the system clock.
- Reports are queued in a FIFO; the CPU pops them with a read of the DATA register.

---
 rtl/kbd_report_fifo_wb.sv | 73 +++++++
 tb/tb_kbd_report_fifo_wb.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/kbd_report_fifo_wb.sv
// kbd_report_fifo_wb: Wishbone-drained FIFO of 32-bit keyboard reports.
// Define KBD_REPORT_LAST_EN to build the LAST report register at address 3.
module kbd_report_fifo_wb #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  wb_addr,
   output logic [31:0] wb_rdata,
   input  logic [31:0] wb_wdata,
   input  logic        wb_we,
   input  logic        wb_cyc,
   output logic        wb_ack,
   input  logic [31:0] kbd_rx_data,
   input  logic        kbd_rx_stb
);
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [31:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] level;
   logic overflow, acc, empty, full, pop, flush, clr_ovf, push, ovf_set;
   logic [31:0] last, rmux;
   logic unused_wdata;
   assign unused_wdata = ^wb_wdata[31:2];
   assign acc = wb_cyc & ~wb_ack;
   assign empty = level == '0;
   assign full = level == (AW+1)'(FIFO_DEPTH);
   assign pop = acc & ~wb_we & (wb_addr == 2'd0) & ~empty;
   assign flush = acc & wb_we & (wb_addr == 2'd2) & wb_wdata[0];
   assign clr_ovf = acc & wb_we & (wb_addr == 2'd2) & wb_wdata[1];
   // a pop on a full FIFO frees the slot the incoming report takes
   assign push = kbd_rx_stb & ~flush & (~full | pop);
   assign ovf_set = kbd_rx_stb & ~flush & full & ~pop;
   always_comb begin
      rmux = wb_addr == 2'd0 ? (empty ? 32'h0 : mem[rd_ptr]) :
             wb_addr == 2'd1 ? {16'h0, 8'(level), 5'h0, overflow, full, empty} :
             wb_addr == 2'd3 ? last : 32'h0;
   end
`ifdef KBD_REPORT_LAST_EN
   always_ff @(posedge clk) begin
      if (rst) last <= '0;
      else if (kbd_rx_stb) last <= kbd_rx_data;
   end
`else
   assign last = '0;
`endif
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= kbd_rx_data;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_ack <= 1'b0;
         wb_rdata <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
         overflow <= 1'b0;
      end else begin
         wb_ack <= acc;
         wb_rdata <= acc & ~wb_we ? rmux : 32'h0;
         overflow <= ovf_set | (overflow & ~clr_ovf);
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
         end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
         end
      end
   end
endmodule

// File: tb/tb_kbd_report_fifo_wb.sv
// tb_kbd_report_fifo_wb: random and directed checks of kbd_report_fifo_wb
// against a queue-based model of the report FIFO.
module tb_kbd_report_fifo_wb;
   localparam int DEPTH = 16;
   logic clk = 0, rst = 1;
   logic [1:0] wb_addr = 0;
   logic [31:0] wb_rdata, wb_wdata = 0, kbd_rx_data = 0;
   logic wb_we = 0, wb_cyc = 0, wb_ack, kbd_rx_stb = 0;
   int errors = 0, checks = 0;
   logic [31:0] q[$];
   logic ovf = 0;
   logic [31:0] last_m = 0;

   kbd_report_fifo_wb #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .wb_addr(wb_addr), .wb_rdata(wb_rdata),
      .wb_wdata(wb_wdata), .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack),
      .kbd_rx_data(kbd_rx_data), .kbd_rx_stb(kbd_rx_stb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] status_m();
      return {16'h0, 8'(q.size()), 5'h0, ovf, q.size() == DEPTH, q.size() == 0};
   endfunction

   function automatic logic [31:0] last_exp();
`ifdef KBD_REPORT_LAST_EN
      return last_m;
`else
      return 32'h0;
`endif
   endfunction

   // a report arriving while the FIFO is in a given state
   function automatic void model_stb(input logic [31:0] d, input bit flushed);
      last_m = d;
      if (flushed) return;
      if (q.size() < DEPTH) q.push_back(d);
      else ovf = 1;
   endfunction

   task automatic do_reset();
      rst = 1; wb_cyc = 0; kbd_rx_stb = 0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 0;
      q.delete(); ovf = 0; last_m = 0;
   endtask

   task automatic push(input logic [31:0] d);
      @(negedge clk);
      kbd_rx_stb = 1; kbd_rx_data = d;
      @(negedge clk) kbd_rx_stb = 0;
      model_stb(d, 0);
   endtask

   task automatic access(input string tag, input logic [1:0] a, input logic we,
                         input logic [31:0] wd, input logic stb, input logic [31:0] sd);
      logic [31:0] exp;
      bit do_pop, fl;
      exp = a == 0 ? (q.size() > 0 ? q[0] : 32'h0) : a == 1 ? status_m() :
            a == 3 ? last_exp() : 32'h0;
      @(negedge clk);
      wb_addr = a; wb_we = we; wb_wdata = wd; wb_cyc = 1;
      kbd_rx_stb = stb; kbd_rx_data = sd;
      @(posedge clk); #1;
      chk({tag, "_ack"}, 32'(wb_ack), 1);
      if (!we) chk(tag, wb_rdata, exp);
      do_pop = !we && a == 0 && q.size() > 0;
      fl = we && a == 2 && wd[0];
      if (do_pop) void'(q.pop_front());
      if (fl) q.delete();
      if (we && a == 2 && wd[1]) ovf = 0;
      if (stb) model_stb(sd, fl);
      @(negedge clk);
      wb_cyc = 0; kbd_rx_stb = 0;
      @(posedge clk); #1;
      chk({tag, "_ack_drop"}, 32'(wb_ack), 0);
      chk({tag, "_rdata_idle"}, wb_rdata, 0);
   endtask

   initial begin
      do_reset();
      #1;
      chk("rst_ack", 32'(wb_ack), 0);
      chk("rst_rdata", wb_rdata, 0);
      access("rst_status", 1, 0, 0, 0, 0);
      access("rst_data", 0, 0, 0, 0, 0);

      push(32'h11223344); push(32'h55667788);
      access("two_status", 1, 0, 0, 0, 0);
      chk("two_status_const", status_m(), 32'h00000200);
      access("two_d0", 0, 0, 0, 0, 0);
      access("two_d1", 0, 0, 0, 0, 0);
      access("two_empty", 1, 0, 0, 0, 0);

      for (int i = 0; i < 17; i++) push(32'h100 + i);
      access("ovf_status", 1, 0, 0, 0, 0);
      chk("ovf_status_const", status_m(), 32'h00001006);
      for (int i = 0; i < 16; i++) access("ovf_drain", 0, 0, 0, 0, 0);
      access("ctrl_clr", 2, 1, 32'h2, 0, 0);
      access("clr_status", 1, 0, 0, 0, 0);

      for (int i = 0; i < DEPTH; i++) push(32'h200 + i);
      access("full_pop_push", 0, 0, 0, 1, 32'hAAA);
      access("full_pp_status", 1, 0, 0, 0, 0);
      chk("full_pp_const", status_m(), 32'h00001002);
      access("flush0", 2, 1, 32'h1, 0, 0);

      access("empty_pop_push", 0, 0, 0, 1, 32'hBBB);
      access("epp_status", 1, 0, 0, 0, 0);
      access("epp_data", 0, 0, 0, 0, 0);

      for (int i = 0; i < 3; i++) push(32'h300 + i);
      access("flush_stb", 2, 1, 32'h1, 1, 32'hCCC);
      access("flush_status", 1, 0, 0, 0, 0);
      access("flush_data", 0, 0, 0, 0, 0);

      push(32'hDEADBEEF);
      access("last", 3, 0, 0, 0, 0);
      access("last_status", 1, 0, 0, 0, 0);

      for (int i = 0; i < DEPTH; i++) push($urandom);
      access("set_wins", 2, 1, 32'h2, 1, 32'hEEE);
      access("set_wins_status", 1, 0, 0, 0, 0);

      for (int n = 0; n < 400; n++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 4) push($urandom);
         else if (r < 6) access("rnd_data", 0, 0, 0, 1'($urandom), $urandom);
         else if (r == 6) access("rnd_status", 1, 0, 0, 1'($urandom), $urandom);
         else if (r == 7) access("rnd_last", 3, 0, 0, 1'($urandom), $urandom);
         else if (r == 8)
            access("rnd_ctrl", 2, 1, {30'h0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0},
                   1'($urandom), $urandom);
         else access("rnd_wr_ign", 2'($urandom_range(0, 1)) | {2{$urandom_range(0, 1) == 1}}, 1,
                     $urandom & 32'hFFFF_FFFC, 1'($urandom), $urandom);
      end

      push(32'h777);
      @(negedge clk);
      wb_cyc = 1; wb_we = 0; wb_addr = 1; rst = 1;
      @(posedge clk); #1;
      chk("midrst_ack", 32'(wb_ack), 0);
      chk("midrst_rdata", wb_rdata, 0);
      @(negedge clk);
      wb_cyc = 0; rst = 0;
      q.delete(); ovf = 0; last_m = 0;
      access("midrst_status", 1, 0, 0, 0, 0);
      access("midrst_last", 3, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
